camera_frame_gen: RTL and testbench
===================================

Name: camera_frame_gen

Overview:
- Dummy 64x64 camera sensor emulator for the camera64x64_dummy design.
- Produces the pixel stream (FRAME_VALID / LINE_VALID / PIX_DATA) that the downstream capture stage consumes.
- Issues a one-cycle LINE_START pulse at each line start, used as TRIG for a downstream per-line triggered counter.
- Runs line/pixel/blanking timing from internal counters under a small FSM, single-shot or continuous.

Parameters:
- H_ACTIVE, 64, active pixels per line (2..256)
- V_ACTIVE, 64, active lines per frame (2..256)
- H_BLANK, 8, horizontal blanking cycles after each line (>=1)
- V_BLANK, 4, vertical blanking cycles after last line's HBLANK (>=1)
- DATA_W, 8, pixel data width (1..16)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-low
- START  in  1  pulse; begins a frame when in IDLE
- CONT  in  1  1 = restart automatically after VBLANK; sampled at end of VBLANK
- MODE  in  2  test-pattern select; sampled at frame start, held for the frame
- FRAME_VALID  out  1  high from first pixel to end of last line's HBLANK
- LINE_VALID  out  1  high during active pixels
- PIX_DATA  out  DATA_W  pixel value, valid when LINE_VALID=1, else 0
- PIX_X  out  8  column index 0..H_ACTIVE-1 (0 outside active)
- PIX_Y  out  8  row index 0..V_ACTIVE-1
- LINE_START  out  1  one-cycle pulse coincident with PIX_X=0 of each line
- FRAME_DONE  out  1  one-cycle pulse on last VBLANK cycle
- BUSY  out  1  high in any state except IDLE
- FRAME_CNT  out  8  completed-frame count, wraps 255->0

Behaviour:
- Reset (RST=0, asynchronous) forces state IDLE.
- Reset values: all outputs 0, FRAME_CNT=0, latched MODE=0.
- All outputs registered; no combinational input-to-output path.
- States and transitions:
  - IDLE: START=1 at edge k -> LINE.
  - LINE: lasts H_ACTIVE cycles -> HBLANK.
  - HBLANK: lasts H_BLANK cycles. If PIX_Y<V_ACTIVE-1: increment PIX_Y, -> LINE. Else -> VBLANK.
  - VBLANK: lasts V_BLANK cycles. Last cycle: FRAME_DONE=1, FRAME_CNT+1 (effective next cycle). Then -> LINE with PIX_Y=0 if CONT=1, else -> IDLE.
- Start latency: after START at edge k, cycle k+1 shows FRAME_VALID=1, LINE_VALID=1, PIX_X=0, PIX_Y=0, LINE_START=1.
- Frame length: V_ACTIVE*(H_ACTIVE+H_BLANK)+V_BLANK cycles; default 64*72+4=4612.
- Continuous mode: first pixel of frame n+1 immediately follows the FRAME_DONE cycle, with no IDLE cycle.
- PIX_X increments each LINE cycle and is 0 in HBLANK/VBLANK/IDLE.
- Patterns (computed as 8-bit, then zero-extended or truncated to DATA_W):
  - MODE 0: PIX_X
  - MODE 1: PIX_Y
  - MODE 2: PIX_X ^ PIX_Y
  - MODE 3: FRAME_CNT
- FRAME_VALID stays 1 across HBLANK between lines and falls on entry to VBLANK.
- START while BUSY=1 is ignored (no restart, no queueing).
- MODE changes mid-frame have no effect until the next frame start.
- CONT deasserted mid-frame: the current frame completes, then IDLE.
- RST asserted mid-frame: immediate abort to the reset values. FRAME_DONE does not pulse and FRAME_CNT clears.

Decomposition:
- Shared package camera_pkg holds:
  - state encoding (IDLE, LINE, HBLANK, VBLANK)
  - pattern mode constants (PAT_X, PAT_Y, PAT_XOR, PAT_FRAME)
  - default geometry constants 64/64/8/4
- One natural sub-module, camera_span_timer: loadable down-counter with terminal-count flag, instantiated once for LINE/HBLANK/VBLANK span timing.
- PIX_X, PIX_Y and FRAME_CNT are plain registers in the top.

Test Plan:
- Reset release, no START, 100 cycles -> all outputs 0, BUSY=0.
- MODE=0, CONT=0, START pulse -> 64-cycle LINE_VALID bursts, PIX_DATA 0..63. 8-cycle gaps, 64 lines, then 4 VBLANK cycles. FRAME_DONE at cycle 4612 after START, FRAME_CNT=1, back to IDLE.
- MODE=2, CONT=1, 3 frames -> PIX_DATA at (x=5, y=3) equals 6. FRAME_DONE pulses exactly 4612 cycles apart. FRAME_CNT reaches 3. LINE_START count is 192.
- MODE=3, CONT=1, run 257 frames -> FRAME_CNT wraps 255->0. Frame 256 pixel data all 0xFF, frame 257 all 0x00.
- START asserted during line 10 -> no effect on timing. MODE changed to 1 mid-frame -> pattern unchanged until next frame.
- RST low at line 20, pixel 30 -> next cycle all outputs 0. START after release -> fresh frame from PIX_Y=0, FRAME_CNT=0.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared types and constants for the dummy 64x64 camera frame generator.
package camera_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LINE   = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } cam_state_e;

    localparam logic [1:0] PAT_X     = 2'd0;
    localparam logic [1:0] PAT_Y     = 2'd1;
    localparam logic [1:0] PAT_XOR   = 2'd2;
    localparam logic [1:0] PAT_FRAME = 2'd3;

    localparam int unsigned DEF_H_ACTIVE = 64;
    localparam int unsigned DEF_V_ACTIVE = 64;
    localparam int unsigned DEF_H_BLANK  = 8;
    localparam int unsigned DEF_V_BLANK  = 4;

    // Span timer width; covers any active/blanking span below 65536 cycles.
    localparam int unsigned SPAN_W = 16;

    // 8-bit test pattern value for one pixel.
    function automatic logic [7:0] pattern_pix(input logic [1:0] mode,
                                               input logic [7:0] x,
                                               input logic [7:0] y,
                                               input logic [7:0] cnt);
        logic [7:0] pix;
        case (mode)
            PAT_X:   pix = x;
            PAT_Y:   pix = y;
            PAT_XOR: pix = x ^ y;
            default: pix = cnt;
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/camera_span_timer.sv
// Loadable saturating down-counter; zero_c marks the last cycle of the loaded span.
module camera_span_timer
    import camera_pkg::*;
#(
    parameter int unsigned W = SPAN_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c,
    output logic         next_zero_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c      = (count_q == '0);
    assign next_zero_c = (count_d == '0);

endmodule

// File: rtl/camera_frame_gen.sv
// Dummy camera sensor: emits FRAME_VALID/LINE_VALID/PIX_DATA timing with test patterns.
module camera_frame_gen
    import camera_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned H_BLANK  = DEF_H_BLANK,
    parameter int unsigned V_BLANK  = DEF_V_BLANK,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              CONT,
    input  logic [1:0]        MODE,
    output logic              FRAME_VALID,
    output logic              LINE_VALID,
    output logic [DATA_W-1:0] PIX_DATA,
    output logic [7:0]        PIX_X,
    output logic [7:0]        PIX_Y,
    output logic              LINE_START,
    output logic              FRAME_DONE,
    output logic              BUSY,
    output logic [7:0]        FRAME_CNT
);

    localparam logic [7:0]        Y_LAST  = 8'(V_ACTIVE - 1);
    localparam logic [SPAN_W-1:0] H_LOAD  = SPAN_W'(H_ACTIVE - 1);
    localparam logic [SPAN_W-1:0] HB_LOAD = SPAN_W'(H_BLANK - 1);
    localparam logic [SPAN_W-1:0] VB_LOAD = SPAN_W'(V_BLANK - 1);

    cam_state_e        state_q, state_d;
    logic [7:0]        pix_x_q, pix_x_d;
    logic [7:0]        pix_y_q, pix_y_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic              frame_valid_q, frame_valid_d;
    logic              line_valid_q, line_valid_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              line_start_q, line_start_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;

    logic              span_load;
    logic [SPAN_W-1:0] span_val;
    logic              span_zero_c;
    logic              span_next_zero_c;

    camera_span_timer #(.W(SPAN_W)) u_span (
        .CLK         (CLK),
        .RST         (RST),
        .load        (span_load),
        .load_val    (span_val),
        .zero_c      (span_zero_c),
        .next_zero_c (span_next_zero_c)
    );

    // Next state, counters and span reloads.
    always_comb begin
        state_d     = state_q;
        pix_x_d     = 8'd0;
        pix_y_d     = pix_y_q;
        frame_cnt_d = frame_cnt_q;
        mode_d      = mode_q;
        span_load   = 1'b0;
        span_val    = '0;
        case (state_q)
            ST_IDLE: begin
                pix_y_d = 8'd0;
                if (START) begin
                    state_d   = ST_LINE;
                    mode_d    = MODE;
                    span_load = 1'b1;
                    span_val  = H_LOAD;
                end
            end
            ST_LINE: begin
                if (span_zero_c) begin
                    state_d   = ST_HBLANK;
                    span_load = 1'b1;
                    span_val  = HB_LOAD;
                end else begin
                    pix_x_d = pix_x_q + 8'd1;
                end
            end
            ST_HBLANK: begin
                if (span_zero_c) begin
                    span_load = 1'b1;
                    if (pix_y_q != Y_LAST) begin
                        state_d  = ST_LINE;
                        pix_y_d  = pix_y_q + 8'd1;
                        span_val = H_LOAD;
                    end else begin
                        state_d  = ST_VBLANK;
                        span_val = VB_LOAD;
                    end
                end
            end
            ST_VBLANK: begin
                if (span_zero_c) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    pix_y_d     = 8'd0;
                    if (CONT) begin
                        state_d   = ST_LINE;
                        mode_d    = MODE;
                        span_load = 1'b1;
                        span_val  = H_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the upcoming cycle, derived from the next state.
    always_comb begin
        frame_valid_d = (state_d == ST_LINE) || (state_d == ST_HBLANK);
        line_valid_d  = (state_d == ST_LINE);
        line_start_d  = line_valid_d && (state_q != ST_LINE);
        frame_done_d  = (state_d == ST_VBLANK) && span_next_zero_c;
        busy_d        = (state_d != ST_IDLE);
        pix_data_d    = '0;
        if (line_valid_d) begin
            pix_data_d = DATA_W'(pattern_pix(mode_d, pix_x_d, pix_y_d, frame_cnt_d));
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_cnt_q   <= '0;
            mode_q        <= '0;
            frame_valid_q <= 1'b0;
            line_valid_q  <= 1'b0;
            pix_data_q    <= '0;
            line_start_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_cnt_q   <= frame_cnt_d;
            mode_q        <= mode_d;
            frame_valid_q <= frame_valid_d;
            line_valid_q  <= line_valid_d;
            pix_data_q    <= pix_data_d;
            line_start_q  <= line_start_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
        end
    end

    assign FRAME_VALID = frame_valid_q;
    assign LINE_VALID  = line_valid_q;
    assign PIX_DATA    = pix_data_q;
    assign PIX_X       = pix_x_q;
    assign PIX_Y       = pix_y_q;
    assign LINE_START  = line_start_q;
    assign FRAME_DONE  = frame_done_q;
    assign BUSY        = busy_q;
    assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_camera_frame_gen.sv
// Randomized self-checking bench for camera_frame_gen against a frame-offset reference model.
module tb_camera_frame_gen;

    localparam int H  = 8;
    localparam int V  = 5;
    localparam int HB = 3;
    localparam int VB = 2;
    localparam int DW = 8;
    localparam int LL = H + HB;
    localparam int FL = V * LL + VB;

    logic          CLK;
    logic          RST;
    logic          START;
    logic          CONT;
    logic [1:0]    MODE;
    logic          FRAME_VALID;
    logic          LINE_VALID;
    logic [DW-1:0] PIX_DATA;
    logic [7:0]    PIX_X;
    logic [7:0]    PIX_Y;
    logic          LINE_START;
    logic          FRAME_DONE;
    logic          BUSY;
    logic [7:0]    FRAME_CNT;

    camera_frame_gen #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .H_BLANK  (HB),
        .V_BLANK  (VB),
        .DATA_W   (DW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .CONT        (CONT),
        .MODE        (MODE),
        .FRAME_VALID (FRAME_VALID),
        .LINE_VALID  (LINE_VALID),
        .PIX_DATA    (PIX_DATA),
        .PIX_X       (PIX_X),
        .PIX_Y       (PIX_Y),
        .LINE_START  (LINE_START),
        .FRAME_DONE  (FRAME_DONE),
        .BUSY        (BUSY),
        .FRAME_CNT   (FRAME_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a frame is just an offset t into FL cycles.
    bit m_busy;
    int m_t;
    int m_cnt;
    int m_mode;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_t    = 0;
        m_cnt  = 0;
        m_mode = 0;
    endtask

    task automatic model_edge();
        if (!RST) begin
            model_reset();
        end else if (!m_busy) begin
            if (START) begin
                m_busy = 1'b1;
                m_t    = 0;
                m_mode = int'(MODE);
            end
        end else if (m_t == FL - 1) begin
            m_cnt = (m_cnt + 1) % 256;
            if (CONT) begin
                m_t    = 0;
                m_mode = int'(MODE);
            end else begin
                m_busy = 1'b0;
            end
        end else begin
            m_t++;
        end
    endtask

    task automatic compare_outputs();
        int line, pos, e_x, e_y, e_data;
        bit e_fv, e_lv, e_ls, e_fd;
        e_fv = 0; e_lv = 0; e_ls = 0; e_fd = 0;
        e_x = 0; e_y = 0; e_data = 0;
        if (m_busy) begin
            line = m_t / LL;
            pos  = m_t % LL;
            if (line < V) begin
                e_fv = 1;
                e_y  = line;
                e_lv = (pos < H);
                e_x  = e_lv ? pos : 0;
                e_ls = (pos == 0);
            end else begin
                e_y  = V - 1;
                e_fd = (m_t == FL - 1);
            end
        end
        if (e_lv) begin
            case (m_mode)
                0:       e_data = e_x;
                1:       e_data = e_y;
                2:       e_data = e_x ^ e_y;
                default: e_data = m_cnt;
            endcase
        end
        check("FRAME_VALID", 32'(FRAME_VALID), 32'(e_fv));
        check("LINE_VALID",  32'(LINE_VALID),  32'(e_lv));
        check("PIX_DATA",    32'(PIX_DATA),    32'(e_data & 255));
        check("PIX_X",       32'(PIX_X),       32'(e_x));
        check("PIX_Y",       32'(PIX_Y),       32'(e_y));
        check("LINE_START",  32'(LINE_START),  32'(e_ls));
        check("FRAME_DONE",  32'(FRAME_DONE),  32'(e_fd));
        check("BUSY",        32'(BUSY),        32'(m_busy));
        check("FRAME_CNT",   32'(FRAME_CNT),   32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        compare_outputs();
    endtask

    int  n, dones, last, ls_cnt, hits;
    bit  wrapped;
    logic [7:0] prev_cnt;

    initial begin
        RST = 1'b0; START = 1'b0; CONT = 1'b0; MODE = 2'd0;
        model_reset();
        #1;
        compare_outputs();
        repeat (3) tick();
        RST = 1'b1;
        repeat (100) tick();

        // Single frame, MODE 0.
        MODE = 2'd0; CONT = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        check("start_line_start", 32'(LINE_START), 32'd1);
        n = 1;
        while (!FRAME_DONE && n < FL + 20) begin
            tick();
            n++;
        end
        check("done_latency", 32'(n), 32'(FL));
        tick();
        check("single_cnt", 32'(FRAME_CNT), 32'd1);
        check("single_idle", 32'(BUSY), 32'd0);

        // Three continuous frames, MODE 2.
        RST = 1'b0; tick(); RST = 1'b1; tick();
        MODE = 2'd2; CONT = 1'b1; START = 1'b1;
        tick();
        dones = 0; ls_cnt = 0; hits = 0; last = 0; n = 0;
        while (dones < 3 && n < 3 * FL + 20) begin
            n++;
            if (LINE_START) ls_cnt++;
            if (LINE_VALID && PIX_X == 8'd5 && PIX_Y == 8'd3) begin
                hits++;
                check("xor_x5_y3", 32'(PIX_DATA), 32'd6);
            end
            if (FRAME_DONE) begin
                dones++;
                if (dones > 1) check("done_gap", 32'(n - last), 32'(FL));
                last = n;
            end
            if (dones == 2 && PIX_Y == 8'd1) CONT = 1'b0;
            if (dones < 3) begin
                START = (dones < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
            end
        end
        START = 1'b0;
        check("cont_dones", 32'(dones), 32'd3);
        check("line_start_count", 32'(ls_cnt), 32'(3 * V));
        check("xor_hits", 32'(hits), 32'd3);
        tick();
        check("cont_idle", 32'(BUSY), 32'd0);
        check("cont_cnt", 32'(FRAME_CNT), 32'd3);

        // 257 frames in MODE 3 to wrap FRAME_CNT.
        RST = 1'b0; tick(); RST = 1'b1; tick();
        MODE = 2'd3; CONT = 1'b1; START = 1'b1;
        tick();
        dones = 0; n = 0; wrapped = 1'b0; prev_cnt = FRAME_CNT;
        while (dones < 257 && n < 257 * FL + 50) begin
            n++;
            if (prev_cnt == 8'hFF && FRAME_CNT == 8'h00) wrapped = 1'b1;
            prev_cnt = FRAME_CNT;
            if (LINE_VALID && dones == 255) check("frame256_data", 32'(PIX_DATA), 32'hFF);
            if (LINE_VALID && dones == 256) check("frame257_data", 32'(PIX_DATA), 32'h00);
            if (FRAME_DONE) dones++;
            if (dones == 256 && PIX_Y == 8'd1) CONT = 1'b0;
            if (dones < 257) begin
                START = (dones < 256) ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
            end
        end
        START = 1'b0;
        check("wrap_dones", 32'(dones), 32'd257);
        check("wrap_seen", 32'(wrapped), 32'd1);
        tick();
        check("wrap_cnt", 32'(FRAME_CNT), 32'd1);

        // START and MODE changes mid-frame must not disturb the frame.
        MODE = 2'd0; CONT = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        n = 1;
        while (!FRAME_DONE && n < FL + 20) begin
            if (PIX_Y == 8'd2 && LINE_VALID && PIX_X < 8'd3) begin
                START = 1'b1;
                MODE  = 2'd1;
            end else begin
                START = 1'b0;
            end
            tick();
            n++;
        end
        START = 1'b0;
        check("restart_ignored_latency", 32'(n), 32'(FL));
        tick();

        // Abort with reset mid-frame, then restart fresh.
        MODE = 2'd1; START = 1'b1;
        tick();
        START = 1'b0;
        n = 0;
        while (!(PIX_Y == 8'd2 && PIX_X == 8'd3) && n < FL) begin
            tick();
            n++;
        end
        check("mode1_data", 32'(PIX_DATA), 32'd2);
        RST = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        check("abort_busy", 32'(BUSY), 32'd0);
        tick();
        RST = 1'b1;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("fresh_y", 32'(PIX_Y), 32'd0);
        check("fresh_cnt", 32'(FRAME_CNT), 32'd0);
        check("fresh_line_start", 32'(LINE_START), 32'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            START = ($urandom_range(0, 15) == 0);
            MODE  = 2'($urandom_range(0, 3));
            CONT  = ($urandom_range(0, 3) != 0);
            RST   = ($urandom_range(0, 599) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, failed so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
